mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single-port data/instruction RAM (synchronous, registered address, 1-cycle read) among three requesters:
//   debug/loader port (DB), control-unit LD/ST port (DT) and instruction fetch (IF).
// - Sits between the processor control/datapath and the RAM; replaces direct addr_in/wren wiring with a req/ack handshake.
// - Fixed priority DB > DT > IF, plus a starvation guard that forces one IF grant after STARVE_LIMIT consecutive losses.
// PARAMETERS
// - DATA_W       16  RAM word / bus width
// - ADDR_W        7  RAM address width (128 words)
// - STARVE_LIMIT  4  consecutive lost arbitrations with IF pending before IF is forced to win (1..15)
// PORTS
// - clock     in   1       rising-edge clock
// - resetn    in   1       synchronous, active-low reset
// - req_db/req_dt/req_if     in  1 each       request; held high with addr/wdata/we stable until matching ack
// - we_db/we_dt              in  1 each       1 = write, 0 = read (IF is read-only)
// - addr_db/addr_dt/addr_if  in  ADDR_W each  word address
// - wdata_db/wdata_dt        in  DATA_W each  write data
// - gnt_db/gnt_dt/gnt_if     out 1 each       one-hot grant, high from ISSUE through RESP
// - ack_db/ack_dt/ack_if     out 1 each       one-cycle completion pulse (RESP)
// - rdata     out  DATA_W  read data, valid while the ack of a read is high, held until next read completes
// - busy      out  1       high in any state other than IDLE
// - mem_addr  out  ADDR_W  RAM address (registered)
// - mem_data  out  DATA_W  RAM write data (registered)
// - mem_wren  out  1       RAM write enable (registered), high only in ISSUE of a write
// - mem_q     in   DATA_W  RAM read data, valid the cycle after address is presented
// BEHAVIOUR
// - Reset (resetn=0 at a clock edge): state=IDLE; all gnt/ack, busy, mem_wren=0; mem_addr, mem_data, rdata=0; starvation count=0.
// - FSM IDLE -> ISSUE -> (read: WAIT ->) RESP -> IDLE; all outputs registered.
//   IDLE : requests sampled here only. No req -> stay IDLE. Else select winner, latch its addr/wdata/we into mem_*, set gnt.
//   ISSUE: mem_addr/mem_data/mem_wren valid for RAM this cycle. Write -> RESP. Read -> WAIT.
//   WAIT : mem_q valid; capture into rdata at end of cycle -> RESP.
//   RESP : ack of granted requester = 1 for exactly this cycle; gnt dropped at exit -> IDLE.
// - Latency from req seen in IDLE (cycle N): gnt at N+1; write ack at N+2; read ack at N+3. Min 1 IDLE cycle between transactions.
// - mem_wren high exactly one cycle per write (ISSUE); 0 in all other states.
// - Priority: DB > DT > IF, unless starve_cnt == STARVE_LIMIT and req_if=1 -> IF wins.
// - starve_cnt: +1 when arbitration in IDLE grants DB or DT while req_if=1; cleared on IF grant or when req_if=0 in IDLE; saturates at STARVE_LIMIT.
// - Requester dropping req after grant: transaction still completes, ack still pulsed (ignored by requester).
// - Simultaneous requests: exactly one granted; others wait, no ack.
// - Inputs other than the winner's are ignored until next IDLE; winner's inputs are latched, so changes after IDLE have no effect.
// - resetn=0 mid-transaction (ISSUE/WAIT/RESP): abort, no ack issued, mem_wren=0 next cycle, IDLE. A write aborted in ISSUE may or may not have been written.
// - Address/data are passed through unchanged; no wrap or range checks (ADDR_W-bit address wraps naturally).
// STRUCTURE
// - Shared include proc_defs.vh: DATA_W/ADDR_W defaults, requester IDs (DB=2'd2, DT=2'd1, IF=2'd0), FSM state encodings.
// - One sub-module: arb_priority_sel (combinational: req vector + starvation flag -> one-hot winner). Rest (FSM, latches, counter) inline.
// TESTING
// - Reset: hold resetn=0 two cycles with all req=1 -> every output 0, busy=0, no grant.
// - IF read: mem[5]=16'h1234, req_if=1 addr_if=5 at N -> gnt_if at N+1, mem_addr=5 mem_wren=0, ack_if and rdata=16'h1234 at N+3.
// - DT write then read: we_dt=1 addr 16'h10 wdata 16'hBEEF -> mem_wren=1 one cycle at N+1, ack_dt at N+2; read addr 16'h10 -> rdata=16'hBEEF.
// - Contention: req_db, req_dt, req_if all raised same cycle, held until own ack -> acks in order DB, DT, IF, never overlapping.
// - Starvation: DB and DT re-request each time after ack, IF held high -> ack_if after exactly 4 DB/DT grants; starve_cnt cleared after it.
// - Abort: DT read, pull resetn=0 in WAIT -> no ack_dt, gnt_dt=0 and state IDLE after edge; next DT read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: default widths, requester IDs, FSM states.
// Requester IDs double as bit positions in the request/grant/ack vectors.
package mem_port_arbiter_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 7;
   localparam int NUM_REQ    = 3;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      RID_IF = 2'd0,
      RID_DT = 2'd1,
      RID_DB = 2'd2
   } req_id_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_e id);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/ack bundle for the three RAM requesters plus the RAM-facing signals.
// slave = arbiter side, master = requesters and RAM.
interface mem_port_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
);
   logic              req_db;
   logic              req_dt;
   logic              req_if;
   logic              we_db;
   logic              we_dt;
   logic [ADDR_W-1:0] addr_db;
   logic [ADDR_W-1:0] addr_dt;
   logic [ADDR_W-1:0] addr_if;
   logic [DATA_W-1:0] wdata_db;
   logic [DATA_W-1:0] wdata_dt;
   logic              gnt_db;
   logic              gnt_dt;
   logic              gnt_if;
   logic              ack_db;
   logic              ack_dt;
   logic              ack_if;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   modport slave (
      input  req_db, req_dt, req_if, we_db, we_dt,
      input  addr_db, addr_dt, addr_if, wdata_db, wdata_dt,
      input  mem_q,
      output gnt_db, gnt_dt, gnt_if, ack_db, ack_dt, ack_if,
      output rdata, busy, mem_addr, mem_data, mem_wren
   );

   modport master (
      output req_db, req_dt, req_if, we_db, we_dt,
      output addr_db, addr_dt, addr_if, wdata_db, wdata_dt,
      output mem_q,
      input  gnt_db, gnt_dt, gnt_if, ack_db, ack_dt, ack_if,
      input  rdata, busy, mem_addr, mem_data, mem_wren
   );

endinterface

// File: rtl/arb_priority_sel.sv
// Combinational fixed-priority pick DB > DT > IF, overridden in favour of IF when the
// starvation guard fires. Zero latency; winner is all-zero when nobody requests.
module arb_priority_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               force_if,
   output logic [NUM_REQ-1:0] win,
   output logic               win_vld
);

   req_id_e win_id;

   always_comb begin
      win_id  = RID_IF;
      win_vld = |req;
      if (force_if && req[RID_IF]) begin
         win_id = RID_IF;
      end else if (req[RID_DB]) begin
         win_id = RID_DB;
      end else if (req[RID_DT]) begin
         win_id = RID_DT;
      end else begin
         win_id = RID_IF;
      end
      win = win_vld ? id_to_onehot(win_id) : '0;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates DB/DT/IF onto a single-port synchronous RAM; grant 1 cycle after request,
// ack 2 (write) or 3 (read) cycles after; losers simply keep req high until served.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clock,
   input  logic                resetn,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               we_q, we_d;
   logic               busy_q, busy_d;
   logic               mem_wren_q, mem_wren_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_data_q, mem_data_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] win;
   logic               win_vld;
   logic               force_if;

   always_comb begin
      req_vec         = '0;
      req_vec[RID_DB] = bus.req_db;
      req_vec[RID_DT] = bus.req_dt;
      req_vec[RID_IF] = bus.req_if;
   end

   assign force_if = (starve_cnt_q == STARVE_MAX);

   arb_priority_sel u_sel (
      .req      (req_vec),
      .force_if (force_if),
      .win      (win),
      .win_vld  (win_vld)
   );

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ack_d        = '0;
      we_d         = we_q;
      mem_wren_d   = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      rdata_d      = rdata_q;
      starve_cnt_d = starve_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_ISSUE;
               gnt_d   = win;
               if (win[RID_DB]) begin
                  mem_addr_d = bus.addr_db;
                  mem_data_d = bus.wdata_db;
                  we_d       = bus.we_db;
               end else if (win[RID_DT]) begin
                  mem_addr_d = bus.addr_dt;
                  mem_data_d = bus.wdata_dt;
                  we_d       = bus.we_dt;
               end else begin
                  mem_addr_d = bus.addr_if;
                  we_d       = 1'b0;
               end
               mem_wren_d = we_d;
            end
            // Count only arbitrations IF lost while it was actually asking.
            if (!bus.req_if || win[RID_IF]) begin
               starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_RESP;
               ack_d   = gnt_q;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            rdata_d = bus.mem_q;
            ack_d   = gnt_q;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         ack_q        <= '0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         mem_wren_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         rdata_q      <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
         mem_wren_q   <= mem_wren_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         rdata_q      <= rdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign bus.gnt_db   = gnt_q[RID_DB];
   assign bus.gnt_dt   = gnt_q[RID_DT];
   assign bus.gnt_if   = gnt_q[RID_IF];
   assign bus.ack_db   = ack_q[RID_DB];
   assign bus.ack_dt   = ack_q[RID_DT];
   assign bus.ack_if   = ack_q[RID_IF];
   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.mem_wren = mem_wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small RAM model plus a scoreboard of expected acks
// (requester, read data, completion cycle) pushed as requests are driven.
module tb_mem_port_arbiter;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(7)) bus ();

   mem_port_arbiter #(.DATA_W(16), .ADDR_W(7), .STARVE_LIMIT(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   logic [15:0] ram [128];
   logic [15:0] ram_q;
   always @(posedge clock) begin
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
      ram_q <= ram[bus.mem_addr];
   end
   assign bus.mem_q = ram_q;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   int          exp_id_q  [$];
   logic [15:0] exp_dat_q [$];
   bit          exp_chk_q [$];
   int          exp_at_q  [$];

   int          o_id, o_at, e_id, e_at;
   logic [15:0] o_dat, e_dat;
   bit          o_clean, e_chk;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_all();
      bus.req_db = 0; bus.req_dt = 0; bus.req_if = 0;
      bus.we_db = 0; bus.we_dt = 0;
      bus.addr_db = '0; bus.addr_dt = '0; bus.addr_if = '0;
      bus.wdata_db = '0; bus.wdata_dt = '0;
   endtask

   task automatic push_exp(input int id, input logic [15:0] dat, input bit chk, input int at);
      exp_id_q.push_back(id); exp_dat_q.push_back(dat);
      exp_chk_q.push_back(chk); exp_at_q.push_back(at);
   endtask

   task automatic pop_exp();
      if (exp_id_q.size() == 0) begin
         e_id = -2; e_dat = '0; e_chk = 0; e_at = -1;
      end else begin
         e_id = exp_id_q.pop_front(); e_dat = exp_dat_q.pop_front();
         e_chk = exp_chk_q.pop_front(); e_at = exp_at_q.pop_front();
      end
   endtask

   // Observes only: ticks until some ack pulses (or budget runs out, id=-1).
   task automatic wait_ack(input int budget);
      o_id = -1; o_dat = '0; o_at = -1; o_clean = 1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!$onehot0({bus.gnt_db, bus.gnt_dt, bus.gnt_if}) ||
             !$onehot0({bus.ack_db, bus.ack_dt, bus.ack_if})) o_clean = 0;
         if (bus.ack_db | bus.ack_dt | bus.ack_if) begin
            o_id  = bus.ack_db ? 2 : (bus.ack_dt ? 1 : 0);
            o_dat = bus.rdata;
            o_at  = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 0;
      bus.req_db = 1; bus.req_dt = 1; bus.req_if = 1;
      bus.we_db = 1; bus.we_dt = 1;
      bus.addr_db = 7'h7f; bus.addr_dt = 7'h7f; bus.addr_if = 7'h7f;
      bus.wdata_db = 16'hffff; bus.wdata_dt = 16'hffff;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.ack_db, bus.ack_dt, bus.ack_if,
              bus.busy, bus.mem_wren} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.ack_db, bus.ack_dt,
                      bus.ack_if, bus.busy, bus.mem_wren});
         end
         n_cmp++;
         if ({bus.mem_addr, bus.mem_data, bus.rdata} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h data=%h rdata=%h required all 0",
                     bus.mem_addr, bus.mem_data, bus.rdata);
         end
      end
      idle_all();
      resetn = 1;
      tick();
   endtask

   task automatic test_db_load();
      logic [6:0]  a [2];
      logic [15:0] d [2];
      a[0] = 7'd5; d[0] = 16'h1234;
      a[1] = 7'd3; d[1] = 16'hABCD;
      for (int k = 0; k < 2; k++) begin
         bus.req_db = 1; bus.we_db = 1; bus.addr_db = a[k]; bus.wdata_db = d[k];
         push_exp(2, 16'h0, 0, cyc + 2);
         tick();
         n_cmp++;
         if ({bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.mem_wren} !== 4'b1001 ||
             bus.mem_addr !== a[k] || bus.mem_data !== d[k]) begin
            n_fail++;
            $display("FAIL db_issue: gnt/wren=%b addr=%h data=%h required 1001 %h %h",
                     {bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.mem_wren},
                     bus.mem_addr, bus.mem_data, a[k], d[k]);
         end
         wait_ack(6);
         pop_exp();
         n_cmp++;
         if (o_id !== e_id || o_at !== e_at) begin
            n_fail++;
            $display("FAIL db_write_ack: id=%0d cyc=%0d required id=%0d cyc=%0d", o_id, o_at, e_id, e_at);
         end
         bus.req_db = 0;
         tick();
         n_cmp++;
         if (ram[a[k]] !== d[k]) begin
            n_fail++;
            $display("FAIL db_ram_content: got %h required %h", ram[a[k]], d[k]);
         end
      end
   endtask

   task automatic test_if_read();
      bus.req_if = 1; bus.addr_if = 7'd5;
      push_exp(0, 16'h1234, 1, cyc + 3);
      tick();
      n_cmp++;
      if ({bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.mem_wren, bus.busy} !== 5'b00101 ||
          bus.mem_addr !== 7'd5) begin
         n_fail++;
         $display("FAIL if_issue: gnt/wren/busy=%b addr=%h required 00101 05",
                  {bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.mem_wren, bus.busy}, bus.mem_addr);
      end
      wait_ack(6);
      pop_exp();
      n_cmp++;
      if (o_id !== e_id || o_dat !== e_dat || o_at !== e_at) begin
         n_fail++;
         $display("FAIL if_read_ack: id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                  o_id, o_dat, o_at, e_id, e_dat, e_at);
      end
      bus.req_if = 0;
      tick(); tick();
      n_cmp++;
      if (bus.rdata !== 16'h1234 || {bus.gnt_if, bus.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL if_rdata_hold: rdata=%h gnt_if/busy=%b required 1234 00",
                  bus.rdata, {bus.gnt_if, bus.busy});
      end
   endtask

   task automatic test_dt_write_read();
      bus.req_dt = 1; bus.we_dt = 1; bus.addr_dt = 7'h10; bus.wdata_dt = 16'hBEEF;
      push_exp(1, 16'h0, 0, cyc + 2);
      tick();
      n_cmp++;
      if (bus.mem_wren !== 1'b1 || bus.gnt_dt !== 1'b1) begin
         n_fail++;
         $display("FAIL dt_write_issue: wren=%b gnt_dt=%b required 1 1", bus.mem_wren, bus.gnt_dt);
      end
      wait_ack(6);
      pop_exp();
      n_cmp++;
      if (o_id !== e_id || o_at !== e_at || bus.mem_wren !== 1'b0) begin
         n_fail++;
         $display("FAIL dt_write_ack: id=%0d cyc=%0d wren=%b required id=%0d cyc=%0d wren=0",
                  o_id, o_at, bus.mem_wren, e_id, e_at);
      end
      bus.req_dt = 0;
      tick();
      bus.req_dt = 1; bus.we_dt = 0; bus.wdata_dt = 16'h0;
      push_exp(1, 16'hBEEF, 1, cyc + 3);
      wait_ack(6);
      pop_exp();
      n_cmp++;
      if (o_id !== e_id || o_dat !== e_dat || o_at !== e_at) begin
         n_fail++;
         $display("FAIL dt_read_ack: id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                  o_id, o_dat, o_at, e_id, e_dat, e_at);
      end
      bus.req_dt = 0;
      tick();
   endtask

   task automatic test_contention();
      bus.req_db = 1; bus.we_db = 0; bus.addr_db = 7'd3;
      bus.req_dt = 1; bus.we_dt = 1; bus.addr_dt = 7'd20; bus.wdata_dt = 16'h5555;
      bus.req_if = 1; bus.addr_if = 7'd5;
      push_exp(2, 16'hABCD, 1, cyc + 3);
      push_exp(1, 16'h0, 0, -1);
      push_exp(0, 16'h1234, 1, -1);
      for (int k = 0; k < 3; k++) begin
         wait_ack(12);
         pop_exp();
         n_cmp++;
         if (o_id !== e_id || (e_chk && o_dat !== e_dat) || (e_at >= 0 && o_at !== e_at) || !o_clean) begin
            n_fail++;
            $display("FAIL contention_%0d: id=%0d data=%h cyc=%0d onehot=%0d required id=%0d data=%h cyc=%0d onehot=1",
                     k, o_id, o_dat, o_at, o_clean, e_id, e_dat, e_at);
         end
         if (o_id == 2) bus.req_db = 0;
         else if (o_id == 1) bus.req_dt = 0;
         else bus.req_if = 0;
         if (o_id < 0) begin idle_all(); break; end
      end
      tick();
      n_cmp++;
      if (ram[20] !== 16'h5555) begin
         n_fail++;
         $display("FAIL contention_dt_write: got %h required 5555", ram[20]);
      end
   endtask

   task automatic test_starvation();
      bus.req_db = 1; bus.we_db = 1; bus.addr_db = 7'd40; bus.wdata_db = 16'h0001;
      bus.req_dt = 1; bus.we_dt = 1; bus.addr_dt = 7'd41; bus.wdata_dt = 16'h0002;
      bus.req_if = 1; bus.addr_if = 7'd5;
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 4; j++) push_exp(2, 16'h0, 0, -1);
         push_exp(0, 16'h1234, 1, -1);
      end
      for (int k = 0; k < 10; k++) begin
         wait_ack(10);
         pop_exp();
         n_cmp++;
         if (o_id !== e_id || (e_chk && o_dat !== e_dat) || !o_clean) begin
            n_fail++;
            $display("FAIL starve_grant_%0d: id=%0d data=%h onehot=%0d required id=%0d data=%h onehot=1",
                     k, o_id, o_dat, o_clean, e_id, e_dat);
         end
         if (o_id < 0) break;
      end
      idle_all();
      tick(); tick();
   endtask

   task automatic test_abort();
      bus.req_dt = 1; bus.we_dt = 0; bus.addr_dt = 7'h10;
      tick();
      tick();
      n_cmp++;
      if ({bus.gnt_dt, bus.busy, bus.ack_dt} !== 3'b110) begin
         n_fail++;
         $display("FAIL abort_pre_wait: gnt_dt/busy/ack_dt=%b required 110", {bus.gnt_dt, bus.busy, bus.ack_dt});
      end
      resetn = 0;
      tick();
      n_cmp++;
      if ({bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.ack_db, bus.ack_dt, bus.ack_if,
           bus.busy, bus.mem_wren} !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_reset: got %b required 00000000",
                  {bus.gnt_db, bus.gnt_dt, bus.gnt_if, bus.ack_db, bus.ack_dt,
                   bus.ack_if, bus.busy, bus.mem_wren});
      end
      resetn = 1;
      push_exp(1, 16'hBEEF, 1, cyc + 3);
      wait_ack(8);
      pop_exp();
      n_cmp++;
      if (o_id !== e_id || o_dat !== e_dat || o_at !== e_at) begin
         n_fail++;
         $display("FAIL abort_retry: id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                  o_id, o_dat, o_at, e_id, e_dat, e_at);
      end
      bus.req_dt = 0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_all();
      test_reset();
      test_db_load();
      test_if_read();
      test_dt_write_read();
      test_contention();
      test_starvation();
      test_abort();
      n_cmp++;
      if (exp_id_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_id_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
